// File: rtl/rebuster_pkg.sv
// rebuster_pkg: shared definitions for the Zorro/SDMAC bus arbiter.
// Holds the arbitration FSM state enum, the owner encodings driven on the
// owner port, and the default number of Zorro request slots.
package rebuster_pkg;
  localparam int NUM_SLOTS_DEFAULT = 5;
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAITFREE,
    ST_GRANT,
    ST_OWNED,
    ST_RELEASE
  } state_e;
  localparam logic [2:0] OWNER_CPU   = 3'd0;
  localparam logic [2:0] OWNER_SDMAC = 3'd1;
  localparam logic [2:0] OWNER_SLOT0 = 3'd2;
endpackage

// File: rtl/rebuster_sync.sv
// rebuster_sync: WIDTH-bit two-flop synchronizer for asynchronous inputs.
// Ports: clk_i core clock; rst_ni asynchronous active-low reset;
//        d_i raw asynchronous inputs; q_o synchronized outputs.
// Both stages reset to RST_VAL (all ones by default, i.e. every active-low
// input reads as inactive while the pipeline refills after reset).
module rebuster_sync #(
  parameter int               WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);
  logic [WIDTH-1:0] s1_q, s2_q;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_q <= RST_VAL;
      s2_q <= RST_VAL;
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
    end
  end
  assign q_o = s2_q;
endmodule

// File: rtl/rebuster_arbiter.sv
// rebuster_arbiter: bus arbiter between the CPU, the SDMAC and NUM_SLOTS
// Zorro slots. Requests the CPU bus, waits for it to be free, grants one
// master (SDMAC first, then round-robin over slots) and tracks ownership.
// Ports:
//   clk100, reset_n_in                 clock and async active-low reset
//   sbr_n_in, ebr_n_in[NUM_SLOTS]      SDMAC / slot bus requests (async)
//   bg_n_in, bgack_n_in, ebgack_n_in   CPU grant, CPU-side and Z2 acks
//   as_n_in                            CPU address strobe
//   br_n_out/_oe                       CPU bus request and enable
//   sbg_n_out/_oe                      SDMAC grant and enable
//   ebg_n_out/_oe[NUM_SLOTS]           slot grants and enables
//   owner                              0=CPU, 1=SDMAC, 2+n=slot n
// Build option: define GRANT_TIMEOUT_EN to drop a grant that has not been
// acknowledged within GRANT_TIMEOUT cycles; otherwise GRANT waits forever.
module rebuster_arbiter
  import rebuster_pkg::*;
#(
  parameter int GRANT_TIMEOUT = 1023,
  parameter int NUM_SLOTS     = NUM_SLOTS_DEFAULT
) (
  input  logic                 clk100,
  input  logic                 reset_n_in,
  input  logic                 sbr_n_in,
  input  logic [NUM_SLOTS-1:0] ebr_n_in,
  input  logic                 bg_n_in,
  input  logic                 bgack_n_in,
  input  logic                 ebgack_n_in,
  input  logic                 as_n_in,
  output logic                 br_n_out,
  output logic                 br_n_oe,
  output logic                 sbg_n_out,
  output logic                 sbg_n_oe,
  output logic [NUM_SLOTS-1:0] ebg_n_out,
  output logic [NUM_SLOTS-1:0] ebg_n_oe,
  output logic [2:0]           owner
);
  localparam int PW = NUM_SLOTS > 1 ? $clog2(NUM_SLOTS) : 1;
  localparam int SW = NUM_SLOTS + 5;

  // Every bus-side input is asynchronous to clk100, so all of them share
  // one synchronizer and every decision below uses the synchronized copy.
  logic [SW-1:0] raw, syn;
  assign raw = {as_n_in, ebgack_n_in, bgack_n_in, bg_n_in, sbr_n_in, ebr_n_in};

  rebuster_sync #(.WIDTH(SW)) u_sync (
    .clk_i (clk100),
    .rst_ni(reset_n_in),
    .d_i   (raw),
    .q_o   (syn)
  );

  logic [NUM_SLOTS-1:0] slot_req;
  logic sd_req, bg_act, bgack_act, ebgack_act, as_act, any_req, any_ack;
  assign slot_req   = ~syn[NUM_SLOTS-1:0];
  assign sd_req     = ~syn[NUM_SLOTS];
  assign bg_act     = ~syn[NUM_SLOTS+1];
  assign bgack_act  = ~syn[NUM_SLOTS+2];
  assign ebgack_act = ~syn[NUM_SLOTS+3];
  assign as_act     = ~syn[NUM_SLOTS+4];
  assign any_req    = sd_req | (|slot_req);
  assign any_ack    = bgack_act | ebgack_act;

  state_e               state_q, state_d;
  logic                 br_n_q, br_n_d;
  logic                 sbg_n_q, sbg_n_d;
  logic [NUM_SLOTS-1:0] ebg_n_q, ebg_n_d;
  logic [2:0]           owner_q, owner_d;
  logic [PW-1:0]        ptr_q, ptr_d;
  logic                 win_sd_q, win_sd_d;
  logic [PW-1:0]        win_slot_q, win_slot_d;
  logic                 oe_q;
  logic                 win_req, tmo;
  logic [PW-1:0]        rr_slot, rr_idx;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] s);
    return (int'(s) == NUM_SLOTS - 1) ? '0 : s + 1'b1;
  endfunction

  // Round-robin search starting at ptr_q; walking k downwards lets the
  // closest requesting slot overwrite any farther one.
  always_comb begin
    rr_slot = ptr_q;
    rr_idx  = '0;
    for (int k = NUM_SLOTS - 1; k >= 0; k--) begin
      rr_idx = PW'((int'(ptr_q) + k) % NUM_SLOTS);
      if (slot_req[rr_idx]) rr_slot = rr_idx;
    end
  end

  assign win_req = win_sd_q ? sd_req : slot_req[win_slot_q];

`ifdef GRANT_TIMEOUT_EN
  localparam int CW = $clog2(GRANT_TIMEOUT + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  // The counter only runs in GRANT; every path into GRANT passes through
  // a non-GRANT state first, so it always starts a grant at zero.
  assign cnt_d = (state_q == ST_GRANT) ? cnt_q + 1'b1 : '0;
  assign tmo   = (state_q == ST_GRANT) && (cnt_q == CW'(GRANT_TIMEOUT - 1));
  always_ff @(posedge clk100 or negedge reset_n_in) begin
    if (!reset_n_in) cnt_q <= '0;
    else             cnt_q <= cnt_d;
  end
`else
  assign tmo = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    br_n_d     = br_n_q;
    sbg_n_d    = sbg_n_q;
    ebg_n_d    = ebg_n_q;
    owner_d    = owner_q;
    ptr_d      = ptr_q;
    win_sd_d   = win_sd_q;
    win_slot_d = win_slot_q;
    case (state_q)
      ST_IDLE: begin
        if (any_req) begin
          state_d = ST_REQ;
          br_n_d  = 1'b0;
        end
      end
      ST_REQ: begin
        if (!any_req) begin
          state_d = ST_IDLE;
          br_n_d  = 1'b1;
        end else if (bg_act) begin
          state_d = ST_WAITFREE;
        end
      end
      ST_WAITFREE: begin
        // Without any requester left there is nobody to latch as winner.
        if (!any_req) begin
          state_d = ST_IDLE;
          br_n_d  = 1'b1;
        end else if (!as_act && !bgack_act && !ebgack_act) begin
          state_d    = ST_GRANT;
          win_sd_d   = sd_req;
          win_slot_d = rr_slot;
          sbg_n_d    = ~sd_req;
          ebg_n_d    = sd_req ? '1 : ~(NUM_SLOTS'(1) << rr_slot);
        end
      end
      ST_GRANT: begin
        if (any_ack) begin
          state_d = ST_OWNED;
          sbg_n_d = 1'b1;
          ebg_n_d = '1;
          br_n_d  = 1'b1;
          owner_d = win_sd_q ? OWNER_SDMAC : OWNER_SLOT0 + 3'(win_slot_q);
          if (!win_sd_q) ptr_d = nxt(win_slot_q);
        end else if (!win_req || tmo) begin
          state_d = ST_IDLE;
          sbg_n_d = 1'b1;
          ebg_n_d = '1;
          br_n_d  = 1'b1;
          if (tmo && !win_sd_q) ptr_d = nxt(win_slot_q);
        end
      end
      ST_OWNED: begin
        if (!any_ack) begin
          state_d = ST_RELEASE;
          owner_d = OWNER_CPU;
        end
      end
      ST_RELEASE: state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk100 or negedge reset_n_in) begin
    if (!reset_n_in) begin
      state_q    <= ST_IDLE;
      br_n_q     <= 1'b1;
      sbg_n_q    <= 1'b1;
      ebg_n_q    <= '1;
      owner_q    <= OWNER_CPU;
      ptr_q      <= '0;
      win_sd_q   <= 1'b0;
      win_slot_q <= '0;
      oe_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      br_n_q     <= br_n_d;
      sbg_n_q    <= sbg_n_d;
      ebg_n_q    <= ebg_n_d;
      owner_q    <= owner_d;
      ptr_q      <= ptr_d;
      win_sd_q   <= win_sd_d;
      win_slot_q <= win_slot_d;
      oe_q       <= 1'b1;
    end
  end

  assign br_n_out  = br_n_q;
  assign br_n_oe   = oe_q;
  assign sbg_n_out = sbg_n_q;
  assign sbg_n_oe  = oe_q;
  assign ebg_n_out = ebg_n_q;
  assign ebg_n_oe  = {NUM_SLOTS{oe_q}};
  assign owner     = owner_q;
endmodule

// File: tb/tb_rebuster_arbiter.sv
// tb_rebuster_arbiter: self-checking bench for rebuster_arbiter.
`timescale 1ns/1ps
module tb_rebuster_arbiter;
  logic       clk100 = 1'b0;
  logic       reset_n_in = 1'b1;
  logic       sbr_n_in = 1'b1;
  logic [4:0] ebr_n_in = 5'b11111;
  logic       bg_n_in = 1'b1;
  logic       bgack_n_in = 1'b1;
  logic       ebgack_n_in = 1'b1;
  logic       as_n_in = 1'b1;
  logic       br_n_out, br_n_oe, sbg_n_out, sbg_n_oe;
  logic [4:0] ebg_n_out, ebg_n_oe;
  logic [2:0] owner;
  int checks = 0;
  int failures = 0;
  int dual = 0;
  int ptr_m = 0;
  bit armed = 1'b0;
  int exp_q[$];

  always #5 clk100 = ~clk100;

  rebuster_arbiter #(.GRANT_TIMEOUT(16), .NUM_SLOTS(5)) dut (
    .clk100     (clk100),
    .reset_n_in (reset_n_in),
    .sbr_n_in   (sbr_n_in),
    .ebr_n_in   (ebr_n_in),
    .bg_n_in    (bg_n_in),
    .bgack_n_in (bgack_n_in),
    .ebgack_n_in(ebgack_n_in),
    .as_n_in    (as_n_in),
    .br_n_out   (br_n_out),
    .br_n_oe    (br_n_oe),
    .sbg_n_out  (sbg_n_out),
    .sbg_n_oe   (sbg_n_oe),
    .ebg_n_out  (ebg_n_out),
    .ebg_n_oe   (ebg_n_oe),
    .owner      (owner)
  );

  always @(negedge clk100)
    if (armed && reset_n_in && $countones({~sbg_n_out, ~ebg_n_out}) > 1) dual++;

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk100);
    #1;
  endtask

  function automatic int gnt_id();
    if (sbg_n_out === 1'b0) return 1;
    for (int i = 0; i < 5; i++) if (ebg_n_out[i] === 1'b0) return 2 + i;
    return -1;
  endfunction

  // CPU side: wait for a bus request, grant the bus, wait for a master grant.
  task automatic arbitrate(output int who);
    int n = 0;
    while (br_n_out !== 1'b0 && n < 20) begin tick(1); n++; end
    bg_n_in = 1'b0;
    as_n_in = 1'b1;
    n = 0;
    while (gnt_id() < 0 && n < 20) begin tick(1); n++; end
    who = gnt_id();
  endtask

  // Granted master acknowledges; CPU then negates its grant.
  task automatic take(input int who, output int got);
    int n = 0;
    if (who == 1) bgack_n_in = 1'b0;
    else ebgack_n_in = 1'b0;
    while (owner !== 3'(who) && n < 10) begin tick(1); n++; end
    got = int'(owner);
    bg_n_in = 1'b1;
    if (who > 1) ptr_m = (who - 1) % 5;
  endtask

  task automatic give_back();
    bgack_n_in = 1'b1;
    ebgack_n_in = 1'b1;
    bg_n_in = 1'b1;
    tick(5);
  endtask

  task automatic pulse_reset();
    reset_n_in = 1'b0;
    ptr_m = 0;
    tick(2);
    reset_n_in = 1'b1;
    tick(2);
  endtask

  task automatic test_reset();
    #2 reset_n_in = 1'b0;
    #2;
    checks++;
    if ({br_n_out, sbg_n_out, ebg_n_out} !== 7'h7f) begin
      failures++; $display("FAIL reset_outs got=%b want=1111111", {br_n_out, sbg_n_out, ebg_n_out});
    end
    checks++;
    if ({br_n_oe, sbg_n_oe, ebg_n_oe} !== 7'h00) begin
      failures++; $display("FAIL reset_oe got=%b want=0000000", {br_n_oe, sbg_n_oe, ebg_n_oe});
    end
    checks++;
    if (owner !== 3'd0) begin failures++; $display("FAIL reset_owner got=%0d want=0", owner); end
    tick(3);
    reset_n_in = 1'b1;
    checks++;
    if ({br_n_oe, sbg_n_oe, ebg_n_oe} !== 7'h00) begin
      failures++; $display("FAIL oe_before_clk got=%b want=0000000", {br_n_oe, sbg_n_oe, ebg_n_oe});
    end
    tick(1);
    checks++;
    if ({br_n_oe, sbg_n_oe, ebg_n_oe} !== 7'h7f) begin
      failures++; $display("FAIL oe_after_clk got=%b want=1111111", {br_n_oe, sbg_n_oe, ebg_n_oe});
    end
    armed = 1'b1;
    tick(3);
  endtask

  task automatic test_sdmac();
    int n = 0, who, e, got;
    sbr_n_in = 1'b0;
    exp_q.push_back(1);
    while (br_n_out !== 1'b0 && n < 10) begin tick(1); n++; end
    checks++;
    if (n > 3) begin failures++; $display("FAIL br_latency got=%0d want<=3", n); end
    bg_n_in = 1'b0;
    as_n_in = 1'b0;
    tick(6);
    checks++;
    if (gnt_id() != -1) begin failures++; $display("FAIL grant_while_as got=%0d want=-1", gnt_id()); end
    arbitrate(who);
    e = exp_q.size() > 0 ? exp_q.pop_front() : -2;
    checks++;
    if (who != e) begin failures++; $display("FAIL sdmac_grant got=%0d want=%0d", who, e); end
    take(1, got);
    checks++;
    if (got != 1) begin failures++; $display("FAIL sdmac_owner got=%0d want=1", got); end
    checks++;
    if ({sbg_n_out, br_n_out} !== 2'b11) begin
      failures++; $display("FAIL sdmac_negate got=%b want=11", {sbg_n_out, br_n_out});
    end
    sbr_n_in = 1'b1;
    give_back();
    checks++;
    if (owner !== 3'd0 || br_n_out !== 1'b1) begin
      failures++; $display("FAIL sdmac_release got=%0d/%b want=0/1", owner, br_n_out);
    end
  endtask

  task automatic test_round_robin();
    int who, e, got;
    ebr_n_in = 5'b00000;
    for (int i = 0; i < 6; i++) exp_q.push_back(2 + (ptr_m + i) % 5);
    for (int i = 0; i < 6; i++) begin
      arbitrate(who);
      e = exp_q.size() > 0 ? exp_q.pop_front() : -2;
      checks++;
      if (who != e) begin failures++; $display("FAIL rr_grant[%0d] got=%0d want=%0d", i, who, e); end
      take(e, got);
      checks++;
      if (got != e) begin failures++; $display("FAIL rr_owner[%0d] got=%0d want=%0d", i, got, e); end
      if (i == 5) ebr_n_in = 5'b11111;
      give_back();
    end
    tick(4);
    checks++;
    if (dual != 0) begin failures++; $display("FAIL rr_exclusive got=%0d want=0", dual); end
  endtask

  task automatic test_priority();
    int who, e, got;
    sbr_n_in = 1'b0;
    ebr_n_in = 5'b11110;
    exp_q.push_back(1);
    exp_q.push_back(2);
    arbitrate(who);
    e = exp_q.size() > 0 ? exp_q.pop_front() : -2;
    checks++;
    if (who != e) begin failures++; $display("FAIL prio_first got=%0d want=%0d", who, e); end
    take(1, got);
    sbr_n_in = 1'b1;
    give_back();
    arbitrate(who);
    e = exp_q.size() > 0 ? exp_q.pop_front() : -2;
    checks++;
    if (who != e) begin failures++; $display("FAIL prio_second got=%0d want=%0d", who, e); end
    take(2, got);
    checks++;
    if (got != 2) begin failures++; $display("FAIL prio_owner got=%0d want=2", got); end
    ebr_n_in = 5'b11111;
    give_back();
  endtask

  task automatic test_drop();
    int n = 0, who, e;
    ebr_n_in = 5'b11011;
    exp_q.push_back(4);
    arbitrate(who);
    e = exp_q.size() > 0 ? exp_q.pop_front() : -2;
    checks++;
    if (who != e) begin failures++; $display("FAIL drop_grant got=%0d want=%0d", who, e); end
    ebr_n_in = 5'b11111;
    while (ebg_n_out[2] !== 1'b1 && n < 10) begin tick(1); n++; end
    checks++;
    if (n > 3) begin failures++; $display("FAIL drop_latency got=%0d want<=3", n); end
    checks++;
    if (br_n_out !== 1'b1 || owner !== 3'd0) begin
      failures++; $display("FAIL drop_idle got=%b/%0d want=1/0", br_n_out, owner);
    end
    bg_n_in = 1'b1;
    tick(5);
    checks++;
    if (br_n_out !== 1'b1 || gnt_id() != -1) begin
      failures++; $display("FAIL drop_stays_idle got=%b/%0d want=1/-1", br_n_out, gnt_id());
    end
  endtask

  task automatic test_reset_owned();
    int who, e, got;
    ebr_n_in = 5'b10111;
    exp_q.push_back(5);
    arbitrate(who);
    e = exp_q.size() > 0 ? exp_q.pop_front() : -2;
    checks++;
    if (who != e) begin failures++; $display("FAIL ro_grant got=%0d want=%0d", who, e); end
    take(5, got);
    checks++;
    if (got != 5) begin failures++; $display("FAIL ro_owner got=%0d want=5", got); end
    #2 reset_n_in = 1'b0;
    ptr_m = 0;
    #1;
    checks++;
    if ({br_n_out, sbg_n_out, ebg_n_out} !== 7'h7f || owner !== 3'd0) begin
      failures++; $display("FAIL ro_async got=%b/%0d want=1111111/0", {br_n_out, sbg_n_out, ebg_n_out}, owner);
    end
    tick(1);
    reset_n_in = 1'b1;
    ebgack_n_in = 1'b1;
    ebr_n_in = 5'b11111;
    tick(6);
    ebr_n_in = 5'b01101;
    exp_q.push_back(2 + 1);
    arbitrate(who);
    e = exp_q.size() > 0 ? exp_q.pop_front() : -2;
    checks++;
    if (who != e) begin failures++; $display("FAIL ro_resume got=%0d want=%0d", who, e); end
    take(e, got);
    ebr_n_in = 5'b11111;
    give_back();
    checks++;
    if (owner !== 3'd0) begin failures++; $display("FAIL ro_release got=%0d want=0", owner); end
  endtask

`ifdef GRANT_TIMEOUT_EN
  task automatic test_timeout();
    int n = 0, who, e, got;
    pulse_reset();
    ebr_n_in = 5'b10101;
    exp_q.push_back(3);
    exp_q.push_back(5);
    arbitrate(who);
    e = exp_q.size() > 0 ? exp_q.pop_front() : -2;
    checks++;
    if (who != e) begin failures++; $display("FAIL to_first got=%0d want=%0d", who, e); end
    while (ebg_n_out[1] !== 1'b1 && n < 40) begin tick(1); n++; end
    checks++;
    if (n != 16) begin failures++; $display("FAIL to_cycles got=%0d want=16", n); end
    bg_n_in = 1'b1;
    tick(2);
    arbitrate(who);
    e = exp_q.size() > 0 ? exp_q.pop_front() : -2;
    checks++;
    if (who != e) begin failures++; $display("FAIL to_next got=%0d want=%0d", who, e); end
    take(e, got);
    ebr_n_in = 5'b11111;
    give_back();
  endtask
`endif

  initial begin
    test_reset();
    test_sdmac();
    test_round_robin();
    test_priority();
    test_drop();
    test_reset_owned();
`ifdef GRANT_TIMEOUT_EN
    test_timeout();
`endif
    checks++;
    if (dual != 0) begin failures++; $display("FAIL exclusive_grants got=%0d want=0", dual); end
    checks++;
    if (exp_q.size() != 0) begin failures++; $display("FAIL scoreboard_left got=%0d want=0", exp_q.size()); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/rebuster_arbiter.md
REBUSTER_ARBITER -- requirements
Module: rebuster_arbiter

Interface
REQ-001 SHALL have parameter GRANT_TIMEOUT, default 1023, the number of clk100 cycles a grant may wait for acknowledge.
REQ-002 SHALL have parameter NUM_SLOTS, default 5, the number of Zorro bus request slots.
REQ-003 clk100 input 1: core clock (100 MHz), single clock domain.
REQ-004 reset_n_in input 1: reset, asynchronous, active-low.
REQ-005 sbr_n_in input 1: SDMAC bus request, active-low, asynchronous.
REQ-006 ebr_n_in input NUM_SLOTS: Zorro slot bus requests, active-low, asynchronous.
REQ-007 bg_n_in input 1: CPU bus grant, active-low.
REQ-008 bgack_n_in input 1: bus grant acknowledge on the CPU side, active-low.
REQ-009 ebgack_n_in input 1: Z2 bus grant acknowledge, active-low.
REQ-010 as_n_in input 1: CPU address strobe, active-low.
REQ-011 br_n_out, br_n_oe output 1 each: CPU bus request and its enable.
REQ-012 sbg_n_out, sbg_n_oe output 1 each: SDMAC grant and its enable.
REQ-013 ebg_n_out, ebg_n_oe output NUM_SLOTS each: slot grants and their enables.
REQ-014 owner output 3: current master (0=CPU, 1=SDMAC, 2..6=slot 0..4).

Function
REQ-015 All asynchronous inputs SHALL pass through a 2-flop synchronizer; all latencies below count from the synchronized value.
REQ-016 The FSM SHALL have the states IDLE, REQ, WAITFREE, GRANT, OWNED and RELEASE.
REQ-017 IDLE SHALL go to REQ when any request is active, asserting br_n_out on the next cycle.
REQ-018 REQ SHALL go to WAITFREE once bg_n_in is low, and SHALL return to IDLE (negating br_n_out) if all requests drop first.
REQ-019 WAITFREE SHALL go to GRANT when as_n_in is high and both acks are high.
REQ-020 On entry to GRANT the winner SHALL be latched, and exactly one grant output SHALL be asserted the following cycle.
REQ-021 Winner priority SHALL be SDMAC first, then round-robin across slots starting at the slot after the last acknowledged slot; the pointer resets to 0.
REQ-022 GRANT SHALL go to OWNED on bgack_n_in or ebgack_n_in low; it then negates the grant and br_n_out, sets owner, and advances the pointer if the winner is a slot.
REQ-023 If the winner's request drops in GRANT before any ack, the grant SHALL be negated and the FSM SHALL go to IDLE.
REQ-024 OWNED SHALL hold until both acks are high, then go to RELEASE.
REQ-025 RELEASE SHALL last 1 cycle with owner=0 before IDLE, so a new arbitration starts no earlier than 1 cycle after release.
REQ-026 At most one of sbg_n_out and ebg_n_out SHALL be low in any cycle.
REQ-027 Requests arriving during GRANT, OWNED or RELEASE SHALL NOT change the latched winner.
REQ-028 All *_oe outputs SHALL be 1 from the first clock after reset deassertion.

Reset
REQ-029 Reset assertion SHALL asynchronously force: all grants and br_n_out high, all *_oe 0, owner=0, FSM=IDLE, pointer=0, timeout counter=0 (including mid-grant).

Configuration
REQ-030 With GRANT_TIMEOUT_EN defined, a grant left unacknowledged for GRANT_TIMEOUT cycles SHALL be negated, the pointer SHALL skip that slot, and the FSM SHALL go to IDLE.
REQ-031 Without GRANT_TIMEOUT_EN, GRANT SHALL wait indefinitely and no counter logic SHALL be synthesized.

Structure
REQ-032 The package rebuster_pkg SHALL hold the FSM state enum, the owner encodings and NUM_SLOTS_DEFAULT.
REQ-033 A sub-module, rebuster_sync (parameterized width, 2-flop), SHALL perform the input synchronization.

Verification
REQ-034 sbr_n_in low alone: br_n_out low within 3 cycles; bg_n_in low with as_n_in high gives sbg_n_out low; bgack_n_in low gives owner=1 and sbg_n_out high.
REQ-035 sbr_n_in and ebr_n_in=5'b11110 low in the same cycle: SDMAC granted first, slot 0 granted after release.
REQ-036 All 5 slots requesting continuously: grants go in order 0,1,2,3,4,0 with never two grants low at once.
REQ-037 Slot 2 request dropped during GRANT: ebg_n_out[2] high next cycle, FSM returns to IDLE, br_n_out high.
REQ-038 Reset pulsed while in OWNED: all grants high and owner=0 immediately; normal arbitration resumes after release.
REQ-039 With GRANT_TIMEOUT_EN and GRANT_TIMEOUT=16, slot 1 never acks: grant negated after 16 cycles, and slot 3 (also requesting) is granted next.
